// File: rtl/fetch_queue_pkg.sv
// Shared rv32i types: the fetch-to-decode pipeline register and the default queue depth.
// The package keeps its codebase name rv32i_types so other blocks can import it unchanged.
package rv32i_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] inst;
    } IF_ID_reg_t;

    localparam int fetch_queue_depth = 8;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode; IF_ID_reg presents the head entry.
// Optional same-cycle empty-queue bypass is enabled with `define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = fetch_queue_depth
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  logic [31:0]                enq_pc,
    input  logic [31:0]                enq_pc_next,
    input  logic [31:0]                enq_inst,
    output logic                       enq_ready,
    input  logic                       stall_in,
    output IF_ID_reg_t                 IF_ID_reg,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    IF_ID_reg_t    mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;

    logic       empty, full, push, pop, byp;
    IF_ID_reg_t enq_entry;

    assign enq_entry = '{pc: enq_pc, pc_next: enq_pc_next, inst: enq_inst};

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign empty     = (head_q == tail_q);
    assign full      = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
    assign enq_ready = !full;
    assign count     = tail_q - head_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = empty && enq_valid && !flush;
`else
    assign byp = 1'b0;
`endif

    // A bypassed entry that decode takes this cycle never touches storage.
    assign push = enq_valid && enq_ready && !flush && !(byp && !stall_in);
    assign pop  = !empty && !stall_in && !flush;

    always_comb begin
        IF_ID_reg = '0;
        if (!empty) begin
            IF_ID_reg = mem_q[head_q[IW-1:0]];
        end else if (byp) begin
            IF_ID_reg = enq_entry;
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (pop)  head_d = head_q + 1'b1;
            if (push) tail_d = tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q[IW-1:0]] <= enq_entry;
        end
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of instruction entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  redirect/mispredict squash from the backend.
REQ-005 SHALL have port enq_valid  input  1  fetch presents a valid instruction this cycle.
REQ-006 SHALL have ports enq_pc, enq_pc_next, enq_inst  input  32 each  fetched pc, predicted next pc, instruction word.
REQ-007 SHALL have port enq_ready  output  1  queue accepts an entry this cycle.
REQ-008 SHALL have port stall_in  input  1  decode cannot consume; driven as DE_stall OR RE_stall.
REQ-009 SHALL have port IF_ID_reg  output  IF_ID_reg_t  head entry {pc, pc_next, inst}; all-zero when no entry is presented.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-011 SHALL be a circular FIFO using head/tail pointers of width $clog2(DEPTH)+1; the extra MSB disambiguates full from empty.
REQ-012 SHALL define empty as head == tail, and full as equal index bits with differing MSBs.
REQ-013 SHALL drive enq_ready = !full; it SHALL NOT depend on stall_in.
REQ-014 SHALL write the enq_* fields at tail and increment tail when enq_valid && enq_ready && !flush.
REQ-015 SHALL drive IF_ID_reg from the head entry whenever not empty; when empty, IF_ID_reg SHALL be '0 (decode treats non-zero as valid).
REQ-016 SHALL pop (increment head) when not empty && !stall_in && !flush; the entry popped is the one decode latches in the same cycle.
REQ-017 SHALL hold IF_ID_reg stable across every cycle in which stall_in is high.
REQ-018 SHALL allow a simultaneous push and pop when neither full nor empty; count is unchanged.
REQ-019 SHALL reject enq_valid while full; the same-cycle pop frees a slot only from the next cycle onward (no pass-through at full).
REQ-020 SHALL, on flush, set head = tail = 0 at the next edge and drop any same-cycle enqueue; IF_ID_reg SHALL be '0 the cycle after flush.
REQ-021 SHALL wrap pointers modulo 2*DEPTH with no special-case logic.
REQ-022 SHALL update count = tail - head (pointer-width arithmetic), range 0..DEPTH.

Reset
REQ-023 SHALL, on rst, clear head, tail, and count; enq_ready = 1 and IF_ID_reg = '0 from the cycle after reset.
REQ-024 SHALL give rst priority over flush, enqueue, and pop; asserting rst mid-operation discards all entries.
REQ-025 SHALL NOT require clearing the entry storage on reset.

Configuration
REQ-026 SHALL, with FETCH_QUEUE_BYPASS_EN defined, present enq_* on IF_ID_reg combinationally when the queue is empty, enq_valid is high, and flush is low.
REQ-027 SHALL, in that bypass case with !stall_in, consume the entry directly: tail and head stay unchanged and nothing is written.
REQ-028 SHALL, in that bypass case with stall_in high, enqueue the entry normally.
REQ-029 SHALL, without FETCH_QUEUE_BYPASS_EN, keep a minimum enqueue-to-IF_ID_reg latency of 1 cycle.

Structure
REQ-030 SHALL take IF_ID_reg_t from the shared rv32i_types package; no new package types are required.
REQ-031 SHALL add a fetch_queue_depth default constant to the shared package if other blocks size against it.
REQ-032 SHALL be a single module with no sub-modules; storage is an unpacked array of IF_ID_reg_t.

Verification
REQ-033 SHALL cover basic flow: push pc=0x1eceb000 inst=0x00500093, stall_in=0 -> next cycle IF_ID_reg.pc=0x1eceb000, count=1; popped and count=0 a cycle later.
REQ-034 SHALL cover fill: 8 pushes with stall_in=1 -> enq_ready=0, count=8; a 9th push is ignored and the head is still the first pc.
REQ-035 SHALL cover full plus pop: at full, enq_valid=1 and stall_in=0 -> pop occurs, push rejected, count=7; next-cycle push accepted, count=8.
REQ-036 SHALL cover wrap-around: 20 push/pop pairs at count=3 -> output pc sequence strictly in push order and count constant at 3.
REQ-037 SHALL cover flush: count=5 with flush and enq_valid=1 -> next cycle count=0, IF_ID_reg='0, enq_ready=1.
REQ-038 SHALL cover bypass: with the macro defined, empty queue and push with stall_in=0 -> IF_ID_reg equals enq_* the same cycle and count stays 0.
